// File: rtl/img_pkg.sv
// Shared constants and types for the binary-image scan / conversion path.
package img_pkg;

  localparam int unsigned DEF_IMG_W = 64;
  localparam int unsigned DEF_IMG_H = 64;
  localparam int unsigned DEF_PIX_W = 8;
  localparam int unsigned FRAME_PIX = DEF_IMG_W * DEF_IMG_H;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } scan_state_t;

  // Counter width that stays legal when the range collapses to a single value.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry pixel FIFO; the head is read straight from a storage register.
module pix_skid_fifo #(
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [PIX_W-1:0] din,
  input  logic             pop,
  input  logic             flush,
  output logic [PIX_W-1:0] dout,
  output logic [1:0]       count,
  output logic             empty,
  output logic             full
);

  logic [PIX_W-1:0] mem_q [2];
  logic [PIX_W-1:0] mem_d [2];
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    empty    = (count_q == 2'd0);
    full     = (count_q == 2'd2);
    count    = count_q;
    dout     = mem_q[rd_ptr_q];
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (flush) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/bin_img_scan_ctrl.sv
// Raster-scans one binary image from pixel memory and streams it to the converter
// with valid/ready, frame/line markers and credit-based backpressure.
module bin_img_scan_ctrl
  import img_pkg::*;
#(
  parameter int unsigned IMG_W  = DEF_IMG_W,
  parameter int unsigned IMG_H  = DEF_IMG_H,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned PIX_W  = DEF_PIX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_rd_data,
  output logic [PIX_W-1:0]  pix_out,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              sof,
  output logic              eol,
  output logic              eof
);

  localparam int unsigned FrameLen = IMG_W * IMG_H;
  localparam int unsigned ColW     = clog2_min1(IMG_W);
  localparam int unsigned RowW     = clog2_min1(IMG_H);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FrameLen - 1);
  localparam logic [ColW-1:0]   LastCol  = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0]   LastRow  = RowW'(IMG_H - 1);

  scan_state_t       state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [RowW-1:0]   row_q, row_d;
  logic              inflight_q, inflight_d;

  logic [PIX_W-1:0]  fifo_dout;
  logic [1:0]        fifo_count;
  logic              fifo_empty, fifo_full;
  logic              kill, pop, last_read;
  logic [2:0]        occ;

  pix_skid_fifo #(
    .PIX_W (PIX_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight_q),
    .din   (mem_rd_data),
    .pop   (pop),
    .flush (kill),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Datapath and host/stream outputs.
  always_comb begin
    kill      = abort && (state_q != StIdle);
    pix_valid = !fifo_empty;
    pop       = pix_valid && pix_ready;
    // Slots already claimed: stored pixels plus the read whose data is on its way back.
    occ       = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
    mem_rd_en = (state_q == StRun) && (occ < 3'd2);
    mem_addr  = rd_addr_q;
    last_read = mem_rd_en && (rd_addr_q == LastAddr);
    pix_out   = pix_valid ? fifo_dout : '0;
    sof       = pix_valid && (col_q == '0) && (row_q == '0);
    eol       = pix_valid && (col_q == LastCol);
    eof       = eol && (row_q == LastRow);
    busy      = (state_q == StRun) || (state_q == StDrain);
    done      = (state_q == StDone);
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    rd_addr_d  = rd_addr_q;
    col_d      = col_q;
    row_d      = row_q;
    inflight_d = mem_rd_en;

    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (last_read) state_d = StDrain;
      StDrain: if (pop && eof) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (mem_rd_en) begin
      rd_addr_d = last_read ? '0 : rd_addr_q + ADDR_W'(1);
    end

    if (pop) begin
      if (col_q == LastCol) begin
        col_d = '0;
        row_d = (row_q == LastRow) ? '0 : row_q + RowW'(1);
      end else begin
        col_d = col_q + ColW'(1);
      end
    end

    // Abort also drops the read issued this cycle so its data is never pushed.
    if (kill) begin
      state_d    = StIdle;
      rd_addr_d  = '0;
      col_d      = '0;
      row_d      = '0;
      inflight_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      rd_addr_q  <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_addr_q  <= rd_addr_d;
      col_q      <= col_d;
      row_q      <= row_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_bin_img_scan_ctrl.sv
// Directed bench for bin_img_scan_ctrl on a 4x2 image with mem[a] = 8'hA0 + a.
module tb_bin_img_scan_ctrl;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst, start, abort, pix_ready;
  logic       busy, done, mem_rd_en, pix_valid, sof, eol, eof;
  logic [2:0] mem_addr;
  logic [7:0] mem_rd_data, pix_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= 8'hA0 + {5'b0, mem_addr};
  end

  bin_img_scan_ctrl #(
    .IMG_W  (W),
    .IMG_H  (H),
    .ADDR_W (3),
    .PIX_W  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .pix_out     (pix_out),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .sof         (sof),
    .eol         (eol),
    .eof         (eof)
  );

  always @(posedge clk) begin
    if (rst === 1'b1 && dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop &&
        !dut.u_fifo.flush) begin
      errors++;
      $display("FAIL fifo_overflow: push into full fifo, count=%0d required<2",
               dut.u_fifo.count);
    end
  end

  function automatic logic [7:0] pix_at(input int i);
    return 8'hA0 + 8'(i);
  endfunction

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({busy, done, mem_rd_en, pix_valid, sof, eol, eof} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctl: got=%b required=0000000",
               {busy, done, mem_rd_en, pix_valid, sof, eol, eof});
    end
    checks++;
    if (mem_addr !== 3'd0 || pix_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_data: addr=%0d pix=%h required 0/00", mem_addr, pix_out);
    end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || pix_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle: busy=%b valid=%b required 0/0", busy, pix_valid);
    end
  endtask

  task automatic test_nominal();
    logic [6:0] exp_ctl;
    logic [7:0] exp_pix;
    logic [2:0] exp_addr;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); start = 1'b0; #1;
      exp_ctl = {(k >= 1 && k <= 10), (k == 11), (k >= 1 && k <= 8), (k >= 3 && k <= 10),
                 (k == 3), (k == 6 || k == 10), (k == 10)};
      exp_pix  = (k >= 3 && k <= 10) ? pix_at(k - 3) : 8'h00;
      exp_addr = (k >= 1 && k <= 8) ? 3'(k - 1) : 3'd0;
      checks++;
      if ({busy, done, mem_rd_en, pix_valid, sof, eol, eof} !== exp_ctl) begin
        errors++;
        $display("FAIL nominal_ctl k=%0d: got=%b required=%b", k,
                 {busy, done, mem_rd_en, pix_valid, sof, eol, eof}, exp_ctl);
      end
      checks++;
      if (pix_out !== exp_pix) begin
        errors++;
        $display("FAIL nominal_pix k=%0d: got=%h required=%h", k, pix_out, exp_pix);
      end
      checks++;
      if (mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL nominal_addr k=%0d: got=%0d required=%0d", k, mem_addr, exp_addr);
      end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0, issued = 0, done_cnt = 0, p;
    logic held = 1'b0;
    logic [7:0] held_pix = 8'h00;
    logic [2:0] held_mk = 3'b000;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk); start = 1'b0;
      pix_ready = !(k >= 5 && k <= 7);
      #1;
      p = int'(pix_valid && pix_ready);
      if (k == 5) begin
        checks++;
        if (pix_out !== pix_at(2) || eol !== 1'b0) begin
          errors++;
          $display("FAIL bp_a2_present: pix=%h eol=%b required A2/0", pix_out, eol);
        end
      end
      if (held) begin
        checks++;
        if (!pix_valid || pix_out !== held_pix || {sof, eol, eof} !== held_mk) begin
          errors++;
          $display("FAIL bp_stable k=%0d: v=%b pix=%h mk=%b required 1/%h/%b", k, pix_valid,
                   pix_out, {sof, eol, eof}, held_pix, held_mk);
        end
      end
      checks++;
      if (issued - acc > 2) begin
        errors++;
        $display("FAIL bp_occupancy k=%0d: got=%0d required<=2", k, issued - acc);
      end
      if (mem_rd_en) begin
        checks++;
        if (issued - acc - p >= 2) begin
          errors++;
          $display("FAIL bp_credit k=%0d: read with occupancy %0d required<2", k,
                   issued - acc - p);
        end
        checks++;
        if (mem_addr !== 3'(issued)) begin
          errors++;
          $display("FAIL bp_addr k=%0d: got=%0d required=%0d", k, mem_addr, issued);
        end
        issued++;
      end
      if (p != 0) begin
        checks++;
        if (pix_out !== pix_at(acc) || sof !== (acc == 0) || eol !== (acc % W == W - 1) ||
            eof !== (acc == N - 1)) begin
          errors++;
          $display("FAIL bp_pixel #%0d: pix=%h mk=%b required %h", acc, pix_out,
                   {sof, eol, eof}, pix_at(acc));
        end
        acc++;
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (acc != N) begin
          errors++;
          $display("FAIL bp_done_early: accepted=%0d required=%0d", acc, N);
        end
      end
      held     = pix_valid && !pix_ready;
      held_pix = pix_out;
      held_mk  = {sof, eol, eof};
    end
    pix_ready = 1'b1;
    checks++;
    if (acc != N || issued != N || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_totals: acc=%0d reads=%0d dones=%0d required %0d/%0d/1", acc, issued,
               done_cnt, N, N);
    end
  endtask

  task automatic test_alternating();
    int acc = 0, last_hs = -10, done_cnt = 0;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk); start = 1'b0;
      pix_ready = (k % 2 == 1);
      #1;
      if (pix_valid && pix_ready) begin
        checks++;
        if (pix_out !== pix_at(acc) || k != 3 + 2 * acc) begin
          errors++;
          $display("FAIL alt_pixel #%0d k=%0d: pix=%h required %h at k=%0d", acc, k, pix_out,
                   pix_at(acc), 3 + 2 * acc);
        end
        acc++;
        last_hs = k;
      end
      if (done) begin
        done_cnt++;
        checks++;
        if (acc != N || k != last_hs + 1) begin
          errors++;
          $display("FAIL alt_done k=%0d: accepted=%0d last_hs=%0d required %0d/k-1", k, acc,
                   last_hs, N);
        end
      end
    end
    pix_ready = 1'b1;
    checks++;
    if (acc != N || done_cnt != 1) begin
      errors++;
      $display("FAIL alt_totals: acc=%0d dones=%0d required %0d/1", acc, done_cnt, N);
    end
  endtask

  task automatic test_abort();
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk); start = 1'b0;
      abort = (k == 8);
      #1;
      if (k == 7) begin
        checks++;
        if (pix_out !== pix_at(4) || !pix_valid) begin
          errors++;
          $display("FAIL abort_a4: pix=%h v=%b required A4/1", pix_out, pix_valid);
        end
      end
      if (k >= 9) begin
        checks++;
        if ({busy, done, mem_rd_en, pix_valid} !== 4'b0) begin
          errors++;
          $display("FAIL abort_idle k=%0d: busy/done/rd/valid=%b required 0000", k,
                   {busy, done, mem_rd_en, pix_valid});
        end
      end
    end
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk); start = 1'b0; #1;
      if (k == 1) begin
        checks++;
        if (mem_rd_en !== 1'b1 || mem_addr !== 3'd0) begin
          errors++;
          $display("FAIL replay_first_read: rd=%b addr=%0d required 1/0", mem_rd_en, mem_addr);
        end
      end
      if (k == 3) begin
        checks++;
        if (pix_out !== pix_at(0) || sof !== 1'b1) begin
          errors++;
          $display("FAIL replay_sof: pix=%h sof=%b required A0/1", pix_out, sof);
        end
      end
      if (k == 6) begin
        checks++;
        if (pix_out !== pix_at(3) || eol !== 1'b1 || eof !== 1'b0) begin
          errors++;
          $display("FAIL replay_eol: pix=%h eol=%b eof=%b required A3/1/0", pix_out, eol, eof);
        end
      end
      checks++;
      if (done !== (k == 11)) begin
        errors++;
        $display("FAIL replay_done k=%0d: got=%b required=%b", k, done, (k == 11));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_pix;
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      start = (k == 4 || k == 11 || k == 12);
      #1;
      checks++;
      if (done !== (k == 11 || k == 23)) begin
        errors++;
        $display("FAIL b2b_done k=%0d: got=%b required=%b", k, done, (k == 11 || k == 23));
      end
      if (k >= 3 && k <= 10) begin
        exp_pix = pix_at(k - 3);
        checks++;
        if (pix_out !== exp_pix || !pix_valid) begin
          errors++;
          $display("FAIL b2b_frame1 k=%0d: pix=%h required %h", k, pix_out, exp_pix);
        end
      end
      if (k == 12) begin
        checks++;
        if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
          errors++;
          $display("FAIL b2b_start_in_done: busy=%b rd=%b required 0/0", busy, mem_rd_en);
        end
      end
      if (k == 13) begin
        checks++;
        if (busy !== 1'b1 || mem_rd_en !== 1'b1 || mem_addr !== 3'd0) begin
          errors++;
          $display("FAIL b2b_frame2_start: busy=%b rd=%b addr=%0d required 1/1/0", busy,
                   mem_rd_en, mem_addr);
        end
      end
      if (k == 15 || k == 22) begin
        exp_pix = (k == 15) ? pix_at(0) : pix_at(7);
        checks++;
        if (pix_out !== exp_pix || sof !== (k == 15) || eof !== (k == 22)) begin
          errors++;
          $display("FAIL b2b_frame2 k=%0d: pix=%h sof=%b eof=%b required %h", k, pix_out, sof,
                   eof, exp_pix);
        end
      end
    end
    start = 1'b0;
  endtask

  task automatic test_rst_drain(input logic with_abort);
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk); start = 1'b0; #1;
    end
    checks++;
    if (busy !== 1'b1 || mem_rd_en !== 1'b0 || !pix_valid) begin
      errors++;
      $display("FAIL rst_in_drain ab=%b: busy=%b rd=%b v=%b required 1/0/1", with_abort, busy,
               mem_rd_en, pix_valid);
    end
    rst = 1'b0; abort = with_abort;
    @(negedge clk); #1;
    checks++;
    if ({busy, done, mem_rd_en, pix_valid, sof, eol, eof, mem_addr, pix_out} !== '0) begin
      errors++;
      $display("FAIL rst_outputs ab=%b: ctl=%b addr=%0d pix=%h required all 0", with_abort,
               {busy, done, mem_rd_en, pix_valid, sof, eol, eof}, mem_addr, pix_out);
    end
    rst = 1'b1; abort = 1'b0;
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if ({busy, done, pix_valid} !== 3'b0) begin
        errors++;
        $display("FAIL rst_after ab=%b: busy/done/valid=%b required 000", with_abort,
                 {busy, done, pix_valid});
      end
    end
  endtask

  task automatic test_restart_after_rst();
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk); start = 1'b0; #1;
      if (k == 3) begin
        checks++;
        if (pix_out !== pix_at(0) || sof !== 1'b1) begin
          errors++;
          $display("FAIL restart_sof: pix=%h sof=%b required A0/1", pix_out, sof);
        end
      end
      if (k == 11) begin
        checks++;
        if (done !== 1'b1) begin
          errors++;
          $display("FAIL restart_done: got=%b required=1", done);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_alternating();
    test_abort();
    test_back_to_back();
    test_rst_drain(1'b0);
    test_rst_drain(1'b1);
    test_restart_after_rst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bin_img_scan_ctrl.md
Name: bin_img_scan_ctrl

Overview:
- Frame sequencer in front of the binary-to-RGB pixel converter.
- On a start pulse, it raster-scans one binary image out of a synchronous pixel memory, address 0 to IMG_W*IMG_H-1.
- It presents each pixel to the converter with a valid/ready handshake, plus frame/line markers, and absorbs downstream backpressure through a 2-entry skid FIFO.
- It reports busy/done to the host and supports abort.

Parameters:
- IMG_W, 64, pixels per line (>=2)
- IMG_H, 64, lines per frame (>=1)
- ADDR_W, 12, memory address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H
- PIX_W, 8, pixel width

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-low (rst==0 sampled at posedge resets the block)
- start  in  1  one-cycle frame request; honoured only in IDLE
- abort  in  1  cancel the current frame; honoured in any non-IDLE state
- busy  out  1  high while a frame is in progress
- done  out  1  one-cycle pulse after the last pixel handshake
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address
- mem_rd_data  in  PIX_W  read data, valid exactly 1 cycle after mem_rd_en
- pix_out  out  PIX_W  pixel to converter (binary_image_pixel)
- pix_valid  out  1  pix_out valid
- pix_ready  in  1  converter accepts pixel
- sof  out  1  qualifies pix_out as pixel (0,0)
- eol  out  1  qualifies pix_out as last pixel of a line
- eof  out  1  qualifies pix_out as last pixel of the frame

Behaviour:
- Reset values:
  - state IDLE; rd_addr, col, row, FIFO count and inflight flag all 0.
  - All outputs 0: busy, done, mem_rd_en, mem_addr, pix_valid, pix_out, sof, eol, eof.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 goes to RUN next cycle.
  - abort is ignored.
  - pix_valid=0.
- RUN:
  - mem_rd_en = (count + inflight - pop) < 2, where pop = pix_valid & pix_ready and inflight = mem_rd_en of the previous cycle.
  - mem_addr = rd_addr; rd_addr increments on each issued read.
  - When the read of address IMG_W*IMG_H-1 is issued, go to DRAIN next cycle.
- DRAIN:
  - mem_rd_en=0.
  - The returning data and FIFO contents continue to drain.
  - On the handshake with eof=1, go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle, then IDLE.
- busy is high in RUN and DRAIN.
- Read data path:
  - mem_rd_data is pushed into the FIFO at the end of the cycle after mem_rd_en.
  - The credit rule guarantees the FIFO never overflows; a push into a full FIFO is a design error (bench assertion).
- Output path:
  - pix_valid = FIFO not empty; pix_out = FIFO head, registered, with no combinational path from mem_rd_data.
  - Simultaneous push and pop keeps the count unchanged.
  - pix_out, sof, eol and eof stay stable while pix_valid & !pix_ready.
- Counters col/row:
  - Track the pixel at the FIFO head and advance on pop.
  - col wraps from IMG_W-1 to 0 and row increments at that point.
  - Markers: sof = (col==0 && row==0); eol = (col==IMG_W-1); eof = eol && (row==IMG_H-1). All are gated by pix_valid.
- Latency:
  - start sampled at edge of cycle 0 → mem_rd_en in cycle 1 → pix_valid with sof in cycle 3.
  - With pix_ready held at 1, the block sustains 1 pixel/cycle.
  - The last handshake is in cycle N+2 (N = IMG_W*IMG_H); done is in cycle N+3.
- abort:
  - Next cycle: state IDLE, FIFO flushed, counters cleared, pix_valid=0, no done pulse.
  - Read data returning the cycle after abort is discarded.
  - If abort and the eof handshake coincide, abort wins: no done.
- start while not IDLE is ignored.
- rst mid-frame behaves like abort, and additionally clears all outputs on the same edge.

Decomposition:
- Shared package img_pkg:
  - FSM state enum scan_state_t (IDLE, RUN, DRAIN, DONE).
  - Default IMG_W/IMG_H/PIX_W constants, shared with the converter and benches.
  - Helper constant FRAME_PIX = IMG_W*IMG_H.
- One sub-module: pix_skid_fifo.
  - 2-entry, PIX_W wide.
  - Ports: push, din, pop, flush, dout, count, empty, full.
  - Synchronous active-low reset.

Test Plan:
- Bench settings for all cases: IMG_W=4, IMG_H=2; memory model mem[a] = 8'hA0+a.
- Nominal frame, pix_ready=1: start at cycle 0 → pix_out A0..A7 on cycles 3..10; sof only with A0; eol with A3 and A7; eof only with A7; done=1 at cycle 11 only; busy high cycles 1..10.
- Backpressure: pix_ready low for 3 cycles while A2 is presented → A2/eol=0 held stable; no mem_rd_en while count+inflight=2; sequence still A0..A7 with no loss or duplication; FIFO never exceeds 2.
- Alternating pix_ready (1,0,1,0…) → pixels are accepted in order A0..A7 at one per two cycles, and done pulses once after the A7 handshake.
- Abort after A4 accepted → next cycle pix_valid=0, busy=0, no done; a following start replays from A0 with sof.
- start asserted during RUN, and two back-to-back frames → mid-frame start ignored; second frame begins only after done and IDLE, again at A0.
- rst=0 for one cycle mid-DRAIN → all outputs 0 the next cycle, state IDLE; rst applied with abort=1 → identical result.
